tx_fifo_arbiter: RTL

- Shares one UART transmit FIFO between two byte sources, e.g. a command responder and a debug/status streamer.
- Grants the FIFO write port round-robin with bounded bursts, so a source can send up to `max_burst` consecutive bytes without interleaving.
- Sits in front of the FIFO's `wr`/`wr_data`/`full` pins and never writes while `full` is asserted.

---
 rtl/tx_fifo_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/tx_fifo_arbiter.sv
// tx_fifo_arbiter: shares one UART transmit FIFO write port between two byte
// sources. Round-robin grants with bounded bursts of up to max_burst bytes.
// Grants are registered. The handshake is combinational from the grant and
// fifo_full only, so valid never reaches ready through a combinational path.
module tx_fifo_arbiter #(
    parameter int data_width = 8,
    parameter int max_burst  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid0,
    input  logic [data_width-1:0] data0,
    output logic                  ready0,
    input  logic                  valid1,
    input  logic [data_width-1:0] data1,
    output logic                  ready1,
    output logic                  gnt0,
    output logic                  gnt1,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [data_width-1:0] fifo_wr_data
);

    localparam int cnt_w = (max_burst > 1) ? $clog2(max_burst) : 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(max_burst - 1);

    localparam logic [1:0] st_idle   = 2'd0;
    localparam logic [1:0] st_grant0 = 2'd1;
    localparam logic [1:0] st_grant1 = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_next_s;
    logic [cnt_w-1:0] cnt_r;
    logic [cnt_w-1:0] cnt_next_s;
    logic             last_r;
    logic             last_next_s;

    // State, burst counter and last-served register; reset makes requester 0 win the first tie
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= st_idle;
            cnt_r   <= {cnt_w{1'b0}};
            last_r  <= 1'b1;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            last_r  <= last_next_s;
        end
    end

    // Arbitration: pick next grant, count burst beats, hold everything while stalled by full
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        last_next_s  = last_r;
        case (state_r)
            st_idle: begin
                if (valid0 && valid1) begin
                    state_next_s = last_r ? st_grant0 : st_grant1;
                end else if (valid0) begin
                    state_next_s = st_grant0;
                end else if (valid1) begin
                    state_next_s = st_grant1;
                end else begin
                    state_next_s = st_idle;
                end
            end
            st_grant0: begin
                if (valid0 && !fifo_full) begin
                    if (cnt_r == cnt_max) begin
                        // Burst end: the other side goes first. Otherwise requester 0,
                        // still valid on this beat, is regranted with a fresh burst.
                        cnt_next_s   = {cnt_w{1'b0}};
                        last_next_s  = 1'b0;
                        state_next_s = valid1 ? st_grant1 : st_grant0;
                    end else begin
                        cnt_next_s = cnt_r + cnt_w'(1'b1);
                    end
                end else if (!valid0) begin
                    cnt_next_s   = {cnt_w{1'b0}};
                    last_next_s  = 1'b0;
                    state_next_s = valid1 ? st_grant1 : st_idle;
                end else begin
                    // Stalled by full: the grant and the count are both held
                    state_next_s = st_grant0;
                    cnt_next_s   = cnt_r;
                end
            end
            st_grant1: begin
                if (valid1 && !fifo_full) begin
                    if (cnt_r == cnt_max) begin
                        cnt_next_s   = {cnt_w{1'b0}};
                        last_next_s  = 1'b1;
                        state_next_s = valid0 ? st_grant0 : st_grant1;
                    end else begin
                        cnt_next_s = cnt_r + cnt_w'(1'b1);
                    end
                end else if (!valid1) begin
                    cnt_next_s   = {cnt_w{1'b0}};
                    last_next_s  = 1'b1;
                    state_next_s = valid0 ? st_grant0 : st_idle;
                end else begin
                    state_next_s = st_grant1;
                    cnt_next_s   = cnt_r;
                end
            end
            default: begin
                state_next_s = st_idle;
                cnt_next_s   = {cnt_w{1'b0}};
            end
        endcase
    end

    // Grant decode and FIFO handshake; a write is never issued while the FIFO is full
    always_comb begin
        gnt0         = (state_r == st_grant0);
        gnt1         = (state_r == st_grant1);
        ready0       = (state_r == st_grant0) & ~fifo_full;
        ready1       = (state_r == st_grant1) & ~fifo_full;
        fifo_wr      = (((state_r == st_grant0) & valid0) |
                        ((state_r == st_grant1) & valid1)) & ~fifo_full;
        fifo_wr_data = (state_r == st_grant1) ? data1 : data0;
    end

endmodule
